// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam int         DIGIT_W   = 4;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder (bit 0 = segment a).
module hex7seg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/hex_disp_arbiter.sv
// Round-robin arbiter sharing the HEX0..HEX5 displays between NUM_REQ requesters.
// Optional blink gating of the segment outputs is built when HEX_BLINK_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a request while hold is low; picks the round-robin winner
// GRANT  | req_ready to the winner; capture its value if it is still valid
// UPDATE | register the decoded, blanked segments from the display register
module hex_disp_arbiter
    import hex_disp_pkg::*;
#(
    parameter  int NUM_DIGITS = 6,
    parameter  int NUM_REQ    = 2,
    parameter  int BLINK_DIV  = 25000000,
    localparam int IDX_W      = $clog2(NUM_REQ),
    localparam int VAL_W      = DIGIT_W * NUM_DIGITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*VAL_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     blank_lz,
    input  logic                     hold,
`ifdef HEX_BLINK_EN
    input  logic                     blink_en,
`endif
    output logic [7*NUM_DIGITS-1:0]  hex,
    output logic [IDX_W-1:0]         owner
);

    if (NUM_REQ < 2 || BLINK_DIV < 1) begin : g_bad_cfg
        $error("hex_disp_arbiter: NUM_REQ must be >= 2 and BLINK_DIV >= 1");
    end

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        win_q, win_d;
    logic [NUM_REQ-1:0]      ready_q, ready_d;
    logic [IDX_W-1:0]        owner_q;
    logic [VAL_W-1:0]        disp_q;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    capture, load_hex;
    logic                    rr_hit;
    logic [IDX_W-1:0]        rr_idx;
    int                      rr_cand;
    logic [6:0]              seg_w [NUM_DIGITS];

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        rr_hit  = 1'b0;
        rr_idx  = '0;
        rr_cand = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!rr_hit && req_valid[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = IDX_W'(rr_cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ready_d  = '0;
        capture  = 1'b0;
        load_hex = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hold && rr_hit) begin
                    win_d           = rr_idx;
                    ready_d[rr_idx] = 1'b1;
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                if (req_valid[win_q]) begin
                    capture = 1'b1;
                    state_d = UPDATE;
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                load_hex = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            ready_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            owner_q <= '0;
            disp_q  <= '0;
        end else if (capture) begin
            disp_q  <= req_data[win_q*VAL_W +: VAL_W];
            owner_q <= win_q;
            ptr_q   <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        end
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
        hex7seg u_dec (
            .nib (disp_q[d*DIGIT_W +: DIGIT_W]),
            .seg (seg_w[d])
        );
    end

    // Walk from the top digit down; once a nonzero nibble is seen everything below shows.
    always_comb begin : blank_mask
        logic seen;
        seen  = 1'b0;
        hex_d = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            seen = seen | (disp_q[d*DIGIT_W +: DIGIT_W] != '0);
            if (!blank_lz || seen || d == 0) begin
                hex_d[d*7 +: 7] = seg_w[d];
            end else begin
                hex_d[d*7 +: 7] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_q <= {NUM_DIGITS{SEG_BLANK}};
        end else if (load_hex) begin
            hex_q <= hex_d;
        end
    end

`ifdef HEX_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    assign hex = (blink_en && blink_phase) ? {NUM_DIGITS{SEG_BLANK}} : hex_q;
`else
    assign hex = hex_q;
`endif

    assign req_ready = ready_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_hex_disp_arbiter.sv
// Self-checking bench for hex_disp_arbiter: directed vectors plus a randomized reference-model run.
module tb_hex_disp_arbiter;

    localparam int ND = 6;
    localparam int NR = 2;
    localparam int BD = 4;
    localparam int VW = 4 * ND;
    localparam logic [41:0] ALL_OFF = {6{7'h7F}};

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*VW-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            blank_lz = 1'b0;
    logic            hold = 1'b0;
    logic            blink_en = 1'b0;
    logic [7*ND-1:0] hex;
    logic            owner;

    int total = 0;
    int bad   = 0;

    hex_disp_arbiter #(.NUM_DIGITS(ND), .NUM_REQ(NR), .BLINK_DIV(BD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .blank_lz  (blank_lz),
        .hold      (hold),
`ifdef HEX_BLINK_EN
        .blink_en  (blink_en),
`endif
        .hex       (hex),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [41:0] render(logic [23:0] v, logic blz);
        logic [41:0] r;
        int msd;
        msd = 0;
        for (int k = 0; k < ND; k++)
            if (((v >> (4 * k)) & 24'hF) != 0) msd = k;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            if (blz && k > msd) r[7*k +: 7] = 7'h7F;
            else                r[7*k +: 7] = glyph[(v >> (4 * k)) & 24'hF];
        end
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(int r, logic [23:0] v, logic blz);
        logic seen;
        blank_lz = blz;
        req_data[r*VW +: VW] = v;
        req_valid[r] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (req_ready[r]) seen = 1'b1;
        end
        if (!seen) check("write_timeout", 0, 1);
        step();
        req_valid[r] = 1'b0;
        step();
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        req_valid = '0;
        hold = 1'b0;
        blink_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    typedef struct {
        logic [23:0] val;
        logic        blz;
        logic [41:0] exp;
    } vec_t;

    vec_t vecs [7];

    // reference model state
    int          m_busy, m_w, m_ptr, m_owner;
    logic [23:0] m_disp;
    logic [41:0] m_hex;
    logic [1:0]  m_ready;
    int          m_cnt;
    logic        m_phase;

    initial begin
        int grants, pend;
        logic [41:0] pend_exp, hex_snap, exp_hex;

        vecs[0] = '{24'h012345, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
        vecs[1] = '{24'h0000A0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40}};
        vecs[2] = '{24'h000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{24'h000000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{24'hFEDCBA, 1'b0, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}};
        vecs[5] = '{24'h006789, 1'b1, {7'h7F, 7'h7F, 7'h02, 7'h78, 7'h00, 7'h10}};
        vecs[6] = '{24'h100001, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}};

        // reset values, sampled mid-cycle with no clock edge needed
        #12;
        check("rst_hex", hex, ALL_OFF);
        check("rst_ready", req_ready, 0);
        check("rst_owner", owner, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // single write latency
        blank_lz = 1'b0;
        req_data[23:0] = 24'h012345;
        req_valid = 2'b01;
        step();
        check("sw_ready", req_ready, 2'b01);
        check("sw_hex_early", hex, ALL_OFF);
        step();
        req_valid = 2'b00;
        check("sw_ready_drop", req_ready, 0);
        step();
        check("sw_hex", hex, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        check("sw_owner", owner, 0);

        for (int i = 0; i < 7; i++) begin
            do_write(0, vecs[i].val, vecs[i].blz);
            check($sformatf("vec%0d_hex", i), hex, vecs[i].exp);
        end

        // reset in the middle of a transfer
        req_data[VW +: VW] = 24'h654321;
        req_valid = 2'b10;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_hex", hex, ALL_OFF);
        check("midrst_ready", req_ready, 0);
        check("midrst_owner", owner, 0);
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // fairness with both requesters continuously valid
        blank_lz = 1'b0;
        req_data = {24'hBBBBBB, 24'hAAAAAA};
        req_valid = 2'b11;
        grants = 0;
        pend = -1;
        pend_exp = '0;
        for (int c = 0; c < 40 && (grants < 4 || pend >= 0); c++) begin
            step();
            check("fair_onehot", req_ready == 2'b11, 0);
            if (c == pend) begin
                check("fair_hex", hex, pend_exp);
                pend = -1;
            end
            if (req_ready != 0 && grants < 4) begin
                check("fair_order", req_ready, 2'b01 << (grants % 2));
                pend_exp = render((grants % 2) ? 24'hBBBBBB : 24'hAAAAAA, 1'b0);
                pend = c + 2;
                grants++;
            end
        end
        check("fair_grants", grants, 4);
        req_valid = '0;
        step();
        step();

        // withdraw during GRANT
        do_write(0, 24'h000777, 1'b0);
        req_data[VW +: VW] = 24'h123456;
        req_valid = 2'b10;
        step();
        check("wd_ready", req_ready, 2'b10);
        req_valid = 2'b00;
        step();
        check("wd_ready_off", req_ready, 0);
        step();
        step();
        check("wd_owner", owner, 0);
        check("wd_hex", hex, render(24'h000777, 1'b0));

        // hold blocks new grants and keeps the display static
        hold = 1'b1;
        req_data[23:0] = 24'h000001;
        req_valid = 2'b01;
        hex_snap = hex;
        for (int c = 0; c < 5; c++) begin
            step();
            check("hold_ready", req_ready, 0);
            check("hold_hex", hex, hex_snap);
        end
        hold = 1'b0;
        step();
        check("hold_resume", req_ready, 2'b01);
        step();
        req_valid = '0;
        step();
        check("hold_hex_after", hex, render(24'h000001, 1'b0));

        // randomized run against the reference model
        do_reset();
        m_busy = 0; m_w = 0; m_ptr = 0; m_owner = 0;
        m_disp = '0; m_hex = ALL_OFF; m_ready = '0;
        m_cnt = 1; m_phase = 1'b0;  // one edge has passed since reset release
        for (int c = 0; c < 800; c++) begin
            logic [1:0]  n_ready;
            logic [41:0] n_hex;
            exp_hex = m_hex;
`ifdef HEX_BLINK_EN
            if (blink_en && m_phase) exp_hex = ALL_OFF;
`endif
            check("rnd_ready", req_ready, m_ready);
            check("rnd_owner", owner, m_owner);
            check("rnd_hex", hex, exp_hex);

            for (int r = 0; r < NR; r++) begin
                if (req_valid[r] && !req_ready[r]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[r] = 1'b0;
                end else begin
                    req_valid[r] = ($urandom_range(0, 1) == 1);
                    req_data[r*VW +: VW] = ($urandom_range(0, 3) == 0) ? 24'(16'($urandom())) : 24'($urandom());
                end
            end
            hold = ($urandom_range(0, 7) == 0);
            blank_lz = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;

            n_ready = '0;
            n_hex = m_hex;
            if (m_busy == 0) begin
                if (!hold && req_valid != 0) begin
                    for (int k = NR - 1; k >= 0; k--)
                        if (req_valid[(m_ptr + k) % NR]) m_w = (m_ptr + k) % NR;
                    n_ready = 2'b01 << m_w;
                    m_busy = 1;
                end
            end else if (m_busy == 1) begin
                if (req_valid[m_w]) begin
                    m_disp = req_data[m_w*VW +: VW];
                    m_owner = m_w;
                    m_ptr = (m_w + 1) % NR;
                    m_busy = 2;
                end else begin
                    m_busy = 0;
                end
            end else begin
                n_hex = render(m_disp, blank_lz);
                m_busy = 0;
            end
            m_ready = n_ready;
            m_hex = n_hex;
            if (m_cnt == BD - 1) begin
                m_cnt = 0;
                m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_disp_arbiter.md
Name: hex_disp_arbiter

Overview:
- Shares the board's bank of six active-low seven-segment displays between NUM_REQ requesters.
- Round-robin arbitration over a valid/ready write handshake.
- Captures the winning 24-bit hex value into a display register.
- Drives registered, decoded segment outputs with optional leading-zero blanking.
- Sits between lab datapath blocks (counters, memory viewers, etc.) and the HEX0..HEX5 pins.

Parameters:
- NUM_DIGITS, 6: number of displays; the value width is 4*NUM_DIGITS.
- NUM_REQ, 2: number of requesters; must be at least 2.
- BLINK_DIV, 25000000: clock cycles per blink half-period. Used only with HEX_BLINK_EN.

Ports:
- clk, input, 1: single system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- req_valid, input, NUM_REQ: per-requester write request.
- req_data, input, NUM_REQ*4*NUM_DIGITS: requester i's value in slice i.
- req_ready, output, NUM_REQ: one-hot grant/accept strobe.
- blank_lz, input, 1: leading-zero blanking enable.
- hold, input, 1: freeze; no new grants issued while high.
- hex, output, 7*NUM_DIGITS: active-low segments. Digit d is in [7d+6:7d], and digit 0 is least significant.
- owner, output, clog2(NUM_REQ): index of the last requester whose write completed.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low.
- Reset values:
  - hex: all 7'h7F (all segments off).
  - req_ready = 0, owner = 0, display register = 0.
  - FSM in IDLE.
  - Round-robin pointer gives requester 0 highest priority.
- FSM state IDLE:
  - If !hold and any req_valid: select the winner by round-robin, starting from the pointer. Register the winner index, then go to GRANT.
  - Otherwise stay in IDLE.
- FSM state GRANT:
  - req_ready[winner] = 1 for exactly this cycle; it is a registered output, so no combinational path from req_valid.
  - If req_valid[winner] is high: capture its req_data slice, set owner = winner, advance the pointer to winner+1 (mod NUM_REQ), go to UPDATE.
  - If req_valid[winner] has dropped: abandon; no capture, pointer unchanged, return to IDLE.
- FSM state UPDATE:
  - Register hex from the decoded display register, applying blanking. Return to IDLE.
- Latency:
  - req_valid first high in IDLE at cycle N → req_ready at N+1 → hex changes at N+3.
  - Best-case throughput is one write per 3 cycles.
- Requester rules:
  - A requester must hold req_valid and req_data stable until it sees req_ready, or withdraw.
  - Non-winning requesters keep waiting and are never dropped.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- hold timing:
  - Sampled only in IDLE.
  - hold rising during GRANT or UPDATE does not abort the in-flight transfer.
  - hex is static while hold is high.
- Decode: hexadecimal 0-F, with all segments (including b/c/e/f on 6, 9, A, etc.) matching the existing hex7seg glyph table.
- Blank pattern is 7'h7F.
- Leading-zero blanking, sampled in UPDATE:
  - If blank_lz: every digit above the most significant nonzero digit is blanked.
  - Digit 0 is never blanked, so a value of 0 shows "0" (7'h40) in digit 0.
  - If !blank_lz: all digits are shown.
- Reset asserted mid-transfer: immediate return to reset values, and the partial transfer is discarded.
- An X/unknown state decodes to IDLE (default arm).

Optional Feature:
- Macro: HEX_BLINK_EN.
- Defined:
  - Adds input port blink_en (1 bit, placed after hold).
  - Adds a free-running counter 0..BLINK_DIV-1 and a phase flop that toggles on each wrap. Both reset to 0.
  - While blink_en=1 and phase=1, hex is forced to all 7'h7F.
  - The display register, FSM and handshake are unaffected.
  - When blink_en deasserts, the true value returns on the next cycle.
- Undefined: no port, no counter, no phase flop; behaviour exactly as above.

Decomposition:
- Package hex_disp_pkg holds:
  - state enum {IDLE, GRANT, UPDATE}.
  - SEG_BLANK = 7'h7F and SEG_ZERO = 7'h40.
  - DIGIT_W = 4.
- Sub-module: NUM_DIGITS instances of the existing combinational hex7seg decoder, one per nibble.
- Blanking mask, arbiter and FSM live in hex_disp_arbiter.

Test Plan:
- Reset check:
  - Stimulus: assert reset_n=0 asynchronously mid-cycle.
  - Required: hex = all 7'h7F, req_ready = 0 and owner = 0, without waiting for a clock edge.
- Single write:
  - Stimulus: requester 0 writes 24'h012345 with blank_lz=0.
  - Required: req_ready = 2'b01 one cycle later. Three cycles after valid, digits 5..0 = 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, and owner = 0.
- Fairness:
  - Stimulus: both requesters continuously valid (24'hAAAAAA and 24'hBBBBBB).
  - Required: grant order 0,1,0,1; req_ready is never 2'b11; each write's value appears in hex.
- Leading-zero blanking:
  - Stimulus: blank_lz=1, write 24'h0000A0. Then write 24'h000000.
  - Required for 24'h0000A0: digits 5..2 = 7'h7F, digit 1 = 7'h08, digit 0 = 7'h40.
  - Required for 24'h000000: only digit 0 shows 7'h40.
- Withdraw and hold:
  - Stimulus: requester 1 drops req_valid during its GRANT cycle. Then raise hold with requester 0 valid.
  - Required: no capture and owner unchanged on withdraw; no req_ready while hold=1; the grant resumes the cycle after hold falls.
- Blink (HEX_BLINK_EN defined, BLINK_DIV=4):
  - Stimulus: blink_en=1.
  - Required: hex alternates between the value and all 7'h7F every 4 cycles; req_ready timing is unchanged.
